// File: rtl/imem_program_loader_pkg.sv
// Shared types and sizes for the instruction-memory program loader.
package imem_program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam int IMEM_BYTES = 1024;
    localparam int WORD_BYTES = 4;
    localparam int LEN_BYTES  = 2;

endpackage

// File: rtl/imem_program_loader_byte_to_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; byte 0 lands in [7:0].
module imem_program_loader_byte_to_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_full
);
    logic [1:0]  r_idx;
    logic [31:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 2'd0;
            r_word <= 32'd0;
        end else if (clear) begin
            r_idx <= 2'd0;
        end else if (push) begin
            r_word[{r_idx, 3'b000} +: 8] <= in_data;
            r_idx                         <= r_idx + 2'd1;
        end
    end

    assign word      = r_word;
    assign word_full = push && (r_idx == 2'd3);

endmodule

// File: rtl/imem_program_loader.sv
// Receives a length-prefixed program image over a byte stream and writes it
// word by word into instruction memory, holding the core in reset until done.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = IMEM_BYTES / WORD_BYTES,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    localparam int LEN_W = 8 * LEN_BYTES;
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_WORDS);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_imem_we;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_error;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_count;

    logic               w_xfer;
    logic               w_word_full;
    logic [LEN_W-1:0]   w_len_full;
    logic [LEN_W-1:0]   w_count_next;

    assign w_xfer       = in_valid && r_in_ready;
    assign w_len_full   = {in_data, r_len[7:0]};
    assign w_count_next = r_count + LEN_W'(1);

    imem_program_loader_byte_to_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     ((r_state == S_LEN1) && w_xfer),
        .push      ((r_state == S_DATA) && w_xfer),
        .in_data   (in_data),
        .word      (imem_wd),
        .word_full (w_word_full)
    );

    // NOTE: every output is a register, so each one is set on the edge that
    // enters a state rather than decoded from r_state afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_imem_we  <= 1'b0;
            r_addr     <= ADDR_BASE;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_len      <= '0;
            r_count    <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_LEN0;
                        r_in_ready <= 1'b1;
                        r_addr     <= ADDR_BASE;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_count    <= '0;
                    end
                end
                S_LEN0: begin
                    if (w_xfer) begin
                        r_len[7:0] <= in_data;
                        r_state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_xfer) begin
                        r_len   <= w_len_full;
                        r_count <= '0;
                        if (w_len_full == '0) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else if (w_len_full > LEN_MAX) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_word_full) begin
                        r_state    <= S_WRITE;
                        r_in_ready <= 1'b0;
                        r_imem_we  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + ADDR_STEP;
                    r_count <= w_count_next;
                    if (w_count_next == r_len) begin
                        r_state    <= S_DONE;
                        r_cpu_hold <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= S_DATA;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign imem_we   = r_imem_we;
    assign imem_addr = r_addr;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule
